mux_scan: RTL
=============

Name: mux_scan

Overview:
- Parametrised registered N-to-1 multiplexer; successor to the single-bit 2-to-1 gate-level mux used in lab boards.
- Selects one of CHANNELS input words of WIDTH bits each.
- Manual mode: channel comes from a select input.
- Auto mode: channels are scanned round-robin with a programmable dwell time and a freeze (hold) control.
- Sits between switch/sensor inputs and LED/HEX display drivers.

Parameters:
WIDTH, 4, bits per channel
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, select/channel index width; must equal ceil(log2(CHANNELS))
DWELL, 4, clock cycles spent on each channel in auto mode (>=1)
CNT_W, 3, dwell counter width; must hold DWELL-1

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
mode  input  1  0 = manual, 1 = auto-scan
sel  input  SEL_W  manual channel select
hold  input  1  auto mode: freeze channel and dwell counter
data_out  output  WIDTH  registered selected channel data
chan_out  output  SEL_W  registered index of channel in data_out
step  output  1  one-cycle pulse when auto scan advances channel

Behaviour:
- Reset (async, immediate, any time incl. mid-scan):
  - data_out=0, chan_out=0, step=0.
  - dwell counter=0, state=S_MAN.
- Per edge, compute chan_next, then:
  - chan_out <= chan_next
  - data_out <= data_in slice[chan_next]
  - data_out always corresponds to chan_out; latency from data_in/sel to outputs is 1 cycle.
- States (registered; next state from mode/hold each cycle):
  - mode=0 -> S_MAN
  - mode=1 & hold=0 -> S_AUTO
  - mode=1 & hold=1 -> S_HOLD
- Channel update uses the current inputs, not the registered state, so a mode change takes effect on the same edge.
- Manual (mode=0):
  - chan_next=sel if sel<CHANNELS; otherwise chan_next=chan_out (out-of-range select ignored).
  - Dwell counter forced to 0; step=0.
- Auto (mode=1, hold=0):
  - counter increments each cycle.
  - When counter==DWELL-1: counter<=0, chan_next=(chan_out==CHANNELS-1)?0:chan_out+1, step<=1.
  - Otherwise chan_next=chan_out, step<=0.
  - DWELL=1: channel advances every cycle and step stays high.
- Hold (mode=1, hold=1):
  - counter, channel, chan_out frozen; step=0.
  - data_out keeps resampling the held channel (live data still flows).
  - hold wins over a simultaneous dwell expiry.
  - On hold release, counting resumes from the frozen count.
- Mode transitions:
  - manual->auto: scan starts from current chan_out with counter=0; first advance after DWELL cycles.
  - auto->manual: sel loaded on that same edge; counter cleared.
- Wrap-around: CHANNELS-1 -> 0, including non-power-of-2 CHANNELS. Index never reaches CHANNELS.
- sel is ignored in auto and hold modes.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset mid-scan, asynchronously between edges -> data_out=0, chan_out=0, step=0 immediately; after release with mode=0, sel=2, data_in=16'hD8A3 -> next edge data_out=4'h8, chan_out=2.
- Manual/live data: mode=0, sel=1, data_in=16'h4321 -> data_out=2; change channel 1 to 4'hF -> data_out=F one edge later; sel=3 -> data_out=4.
- Auto scan, DWELL=4, CHANNELS=4, start chan 0:
  - chan_out sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0.
  - step high exactly on the edges entering 1, 2, 3, 0.
- Hold: in auto, assert hold at counter=2 on chan 1 for 10 cycles -> chan_out stays 1, step=0; release -> advance to 2 after exactly 2 more cycles (counter resumes at 2). Hold asserted on the expiry cycle -> no advance.
- Out-of-range: CHANNELS=3, SEL_W=2, mode=0, sel=1 then sel=3 -> chan_out stays 1; auto scan wraps 2->0, never shows 3.
- Mode switches and DWELL=1:
  - auto at chan 2 -> mode=0, sel=0: chan_out=0 next edge.
  - back to auto: first advance 4 cycles later.
  - DWELL=1 build: chan_out increments every cycle, step constantly 1.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: registered CHANNELS-to-1 word multiplexer for display paths.
// The channel comes from `sel` in manual mode. In auto mode the channels are
// scanned round-robin: the block dwells DWELL cycles on each channel, and
// `hold` freezes both the channel and the dwell count.
// data_out always carries the live data of the channel reported on chan_out.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4,
  parameter int CNT_W    = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      step
);

  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_AUTO = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CHAN_LAST = SEL_W'(CHANNELS - 1);

  state_t                         state, state_next;
  logic [CNT_W-1:0]               cnt, cnt_cur, cnt_next;
  logic [SEL_W-1:0]               chan_next;
  logic                           step_next;
  logic                           sel_ok;
  logic [CHANNELS-1:0][WIDTH-1:0] chans;

  // Channel k occupies data_in[k*WIDTH +: WIDTH], so the flat bus maps
  // directly onto a packed array of words.
  assign chans  = data_in;
  assign sel_ok = (32'(sel) < 32'(CHANNELS));

  // State register: records which mode was in force on the last edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_MAN;
    else       state <= state_next;
  end

  // Next state: decoded from the current mode/hold inputs only.
  always_comb begin
    state_next = S_MAN;
    if (mode) state_next = hold ? S_HOLD : S_AUTO;
  end

  // Next channel, dwell count and step pulse. This process acts on the
  // incoming state, so a mode change takes effect on the same edge.
  // A scan that starts from manual always begins with a fresh dwell count.
  always_comb begin
    cnt_cur   = (state == S_MAN) ? '0 : cnt;
    chan_next = chan_out;
    cnt_next  = cnt_cur;
    step_next = 1'b0;
    case (state_next)
      S_MAN: begin
        cnt_next = '0;
        if (sel_ok) chan_next = sel;
      end
      S_AUTO: begin
        if (cnt_cur == CNT_LAST) begin
          cnt_next  = '0;
          chan_next = (chan_out == CHAN_LAST) ? '0 : chan_out + 1'b1;
          step_next = 1'b1;
        end else begin
          cnt_next = cnt_cur + 1'b1;
        end
      end
      default: ; // S_HOLD: channel and count frozen, no step
    endcase
  end

  // Output and dwell registers. data_out is re-sampled on every edge, so a
  // held channel still shows live input data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      chan_out <= '0;
      data_out <= '0;
      step     <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      chan_out <= chan_next;
      data_out <= chans[chan_next];
      step     <= step_next;
    end
  end

endmodule
